// File: rtl/soc_pm_th_scan_if.sv
// Pixel-matrix digital configuration bus: 24 reserved bits plus an 8-bit threshold.
interface soc_pm_digital_config;
  logic [23:0] res;
  logic [7:0]  th;

  modport master (output res, th);
  modport slave  (input  res, th);
endinterface

// File: rtl/soc_pm_th_scan.sv
// Pixel-matrix configuration driver: committed config word in normal mode,
// autonomous threshold sweep with per-point dwell and strobe in scan mode.
module soc_pm_th_scan (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] cfg_wdata,
  input  logic        cfg_we,
  input  logic        cfg_commit,
  input  logic [7:0]  scan_start,
  input  logic [7:0]  scan_stop,
  input  logic [7:0]  scan_step,
  input  logic [15:0] scan_dwell,
  input  logic        scan_go,
  input  logic        scan_abort,
  output logic        busy,
  output logic        step_pulse,
  output logic        done,
  soc_pm_digital_config.master digital_config
);

  localparam int unsigned CFG_W = 32;
  localparam int unsigned TH_W  = 8;
  localparam int unsigned RES_W = CFG_W - TH_W;
  localparam int unsigned CNT_W = 16;

  typedef enum logic {IDLE, DWELL} state_t;

  state_t             state_q, state_d;
  logic [CFG_W-1:0]   pending_q, pending_d;
  logic [CFG_W-1:0]   active_q, active_d;
  logic [RES_W-1:0]   res_q, res_d;
  logic [TH_W-1:0]    th_q, th_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [TH_W-1:0]    stop_q, stop_d;
  logic [TH_W-1:0]    step_q, step_d;
  logic [CNT_W-1:0]   dwell_q, dwell_d;
  logic               busy_q, busy_d;
  logic               step_pulse_q, step_pulse_d;
  logic               done_q, done_d;
  logic [TH_W:0]      next_th;

  // Register path and sweep sequencing; every output is a function of next state.
  always_comb begin
    state_d   = state_q;
    pending_d = cfg_we ? cfg_wdata : pending_q;
    active_d  = active_q;
    res_d     = active_q[CFG_W-1:TH_W];
    th_d      = th_q;
    cnt_d     = cnt_q;
    stop_d    = stop_q;
    step_d    = step_q;
    dwell_d   = dwell_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    // 9-bit sum so a point past 255 terminates instead of wrapping
    next_th   = (TH_W+1)'(th_q) + (TH_W+1)'(step_q);

    if (cfg_commit) begin
      active_d = cfg_we ? cfg_wdata : pending_q;
    end

    case (state_q)
      IDLE: begin
        th_d   = active_q[TH_W-1:0];
        busy_d = 1'b0;
        if (scan_go && (scan_step != '0)) begin
          state_d = DWELL;
          th_d    = scan_start;
          cnt_d   = scan_dwell;
          stop_d  = scan_stop;
          step_d  = scan_step;
          dwell_d = scan_dwell;
          busy_d  = 1'b1;
        end
      end
      DWELL: begin
        if (scan_abort) begin
          state_d = IDLE;
          th_d    = active_q[TH_W-1:0];
          cnt_d   = '0;
          busy_d  = 1'b0;
        end else if (cnt_q == '0) begin
          if (next_th <= (TH_W+1)'(stop_q)) begin
            th_d  = next_th[TH_W-1:0];
            cnt_d = dwell_q;
          end else begin
            state_d = IDLE;
            th_d    = active_q[TH_W-1:0];
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase

    // strobe lands in the last cycle of each point
    step_pulse_d = (state_d == DWELL) && (cnt_d == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      pending_q    <= '0;
      active_q     <= '0;
      res_q        <= '0;
      th_q         <= '0;
      cnt_q        <= '0;
      stop_q       <= '0;
      step_q       <= '0;
      dwell_q      <= '0;
      busy_q       <= 1'b0;
      step_pulse_q <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      pending_q    <= pending_d;
      active_q     <= active_d;
      res_q        <= res_d;
      th_q         <= th_d;
      cnt_q        <= cnt_d;
      stop_q       <= stop_d;
      step_q       <= step_d;
      dwell_q      <= dwell_d;
      busy_q       <= busy_d;
      step_pulse_q <= step_pulse_d;
      done_q       <= done_d;
    end
  end

  assign busy               = busy_q;
  assign step_pulse         = step_pulse_q;
  assign done               = done_q;
  assign digital_config.res = res_q;
  assign digital_config.th  = th_q;

endmodule

// File: tb/tb_soc_pm_th_scan.sv
// Directed self-checking bench for soc_pm_th_scan.
module tb_soc_pm_th_scan;

  logic        clk;
  logic        rst_n;
  logic [31:0] cfg_wdata;
  logic        cfg_we;
  logic        cfg_commit;
  logic [7:0]  scan_start;
  logic [7:0]  scan_stop;
  logic [7:0]  scan_step;
  logic [15:0] scan_dwell;
  logic        scan_go;
  logic        scan_abort;
  logic        busy;
  logic        step_pulse;
  logic        done;

  int checks;
  int failures;

  soc_pm_digital_config dc ();

  soc_pm_th_scan dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .cfg_wdata      (cfg_wdata),
    .cfg_we         (cfg_we),
    .cfg_commit     (cfg_commit),
    .scan_start     (scan_start),
    .scan_stop      (scan_stop),
    .scan_step      (scan_step),
    .scan_dwell     (scan_dwell),
    .scan_go        (scan_go),
    .scan_abort     (scan_abort),
    .busy           (busy),
    .step_pulse     (step_pulse),
    .done           (done),
    .digital_config (dc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance one clock; sample 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_outs(input string tag, input logic [7:0] th, input logic bsy,
                            input logic sp, input logic dn);
    check({tag, ".th"}, 32'(dc.th), 32'(th));
    check({tag, ".busy"}, 32'(busy), 32'(bsy));
    check({tag, ".step_pulse"}, 32'(step_pulse), 32'(sp));
    check({tag, ".done"}, 32'(done), 32'(dn));
  endtask

  // Expected trace of a sweep from cycle c0 through the done cycle; the point
  // count is supplied by the caller. Leaves the bench in the cycle after done.
  task automatic sweep_check(input string tag, input int start, input int step,
                             input int dwell, input int pts, input logic [7:0] idle_th,
                             input int c0);
    int total;
    total = pts * (dwell + 1);
    for (int c = c0; c <= total + 1; c++) begin
      if (c <= total)
        check_outs($sformatf("%s.c%0d", tag, c),
                   8'(start + ((c - 1) / (dwell + 1)) * step), 1'b1,
                   (c % (dwell + 1)) == 0, 1'b0);
      else
        check_outs($sformatf("%s.c%0d", tag, c), idle_th, 1'b0, 1'b0, 1'b1);
      tick();
    end
    check_outs({tag, ".after"}, idle_th, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic go(input logic [7:0] start, input logic [7:0] stop,
                    input logic [7:0] step, input logic [15:0] dwell);
    scan_start = start;
    scan_stop  = stop;
    scan_step  = step;
    scan_dwell = dwell;
    scan_go    = 1'b1;
    tick();
    scan_go    = 1'b0;
  endtask

  initial begin
    checks     = 0;
    failures   = 0;
    rst_n      = 1'b0;
    cfg_wdata  = '0;
    cfg_we     = 1'b0;
    cfg_commit = 1'b0;
    scan_start = '0;
    scan_stop  = '0;
    scan_step  = '0;
    scan_dwell = '0;
    scan_go    = 1'b0;
    scan_abort = 1'b0;

    tick();
    tick();
    check("rst.res", 32'(dc.res), 32'h0);
    check_outs("rst", 8'h00, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    tick();

    // Pending write without commit leaves outputs untouched
    cfg_wdata = 32'hABCDEF42;
    cfg_we    = 1'b1;
    tick();
    cfg_we = 1'b0;
    tick();
    tick();
    check("nocommit.res", 32'(dc.res), 32'h0);
    check("nocommit.th", 32'(dc.th), 32'h0);

    cfg_commit = 1'b1;
    tick();
    cfg_commit = 1'b0;
    tick();
    check("commit.res", 32'(dc.res), 32'hABCDEF);
    check("commit.th", 32'(dc.th), 32'h42);

    // Write-through
    cfg_wdata  = 32'h00000007;
    cfg_we     = 1'b1;
    cfg_commit = 1'b1;
    tick();
    cfg_we     = 1'b0;
    cfg_commit = 1'b0;
    tick();
    check("wthru.res", 32'(dc.res), 32'h0);
    check("wthru.th", 32'(dc.th), 32'h07);

    // Basic sweep 10,15,20 with dwell 3; params changed after start must not matter
    go(8'd10, 8'd20, 8'd5, 16'd3);
    scan_stop  = 8'd255;
    scan_step  = 8'd1;
    scan_dwell = 16'd0;
    sweep_check("basic", 10, 5, 3, 3, 8'h07, 1);

    // Overflow guard: 250+10 exceeds 255, single point
    go(8'd250, 8'd255, 8'd10, 16'd0);
    sweep_check("ovf", 250, 10, 0, 1, 8'h07, 1);

    // start > stop yields exactly one point
    go(8'd30, 8'd20, 8'd1, 16'd1);
    sweep_check("rev", 30, 1, 1, 1, 8'h07, 1);

    // Abort in cycle 15 of a long sweep
    go(8'd0, 8'd255, 8'd1, 16'd9);
    for (int c = 1; c <= 15; c++) begin
      check_outs($sformatf("abort.c%0d", c), 8'((c - 1) / 10), 1'b1, (c % 10) == 0, 1'b0);
      if (c == 15) scan_abort = 1'b1;
      tick();
    end
    scan_abort = 1'b0;
    check_outs("abort.c16", 8'h07, 1'b0, 1'b0, 1'b0);
    tick();
    check_outs("abort.c17", 8'h07, 1'b0, 1'b0, 1'b0);

    // Abort while idle has no effect
    scan_abort = 1'b1;
    tick();
    scan_abort = 1'b0;
    check_outs("abort_idle", 8'h07, 1'b0, 1'b0, 1'b0);

    // Zero step is ignored
    go(8'd5, 8'd9, 8'd0, 16'd1);
    check("step0.busy1", 32'(busy), 32'h0);
    tick();
    check("step0.busy2", 32'(busy), 32'h0);
    check("step0.th", 32'(dc.th), 32'h07);

    // Commit mid-sweep: res follows, th keeps sweeping, new th after done
    go(8'd10, 8'd20, 8'd5, 16'd3);
    check_outs("mid.c1", 8'd10, 1'b1, 1'b0, 1'b0);
    tick();
    check_outs("mid.c2", 8'd10, 1'b1, 1'b0, 1'b0);
    cfg_wdata  = 32'h11111199;
    cfg_we     = 1'b1;
    cfg_commit = 1'b1;
    tick();
    cfg_we     = 1'b0;
    cfg_commit = 1'b0;
    check("mid.res_c3", 32'(dc.res), 32'h0);
    tick();
    check("mid.res_c4", 32'(dc.res), 32'h111111);
    sweep_check("mid", 10, 5, 3, 3, 8'h99, 4);
    check("mid.res_end", 32'(dc.res), 32'h111111);

    // Asynchronous reset between edges during a sweep
    go(8'd1, 8'd200, 8'd1, 16'd2);
    tick();
    tick();
    check("prerst.busy", 32'(busy), 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst.res", 32'(dc.res), 32'h0);
    check_outs("arst", 8'h00, 1'b0, 1'b0, 1'b0);
    tick();
    rst_n = 1'b1;
    tick();
    check_outs("post_rst", 8'h00, 1'b0, 1'b0, 1'b0);

    go(8'd1, 8'd3, 8'd2, 16'd1);
    sweep_check("rerun", 1, 2, 1, 2, 8'h00, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    failures++;
    $display("FAIL timeout got=running exp=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

endmodule
